// File: rtl/fp_mul_seq.sv
// Sequential signed fixed-point multiplier, shift-add over magnitudes.
// Define FP_MUL_ROUND_EN for round-half-away-from-zero instead of truncation.
module fp_mul_seq #(
  parameter int FP_WIDTH = 25,
  parameter int FP_INT   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [FP_WIDTH-1:0] a,
  input  logic [FP_WIDTH-1:0] b,
  output logic                busy,
  output logic                done,
  output logic                valid,
  output logic                ovf,
  output logic [FP_WIDTH-1:0] val
);

  localparam int FBITS = FP_WIDTH - FP_INT;
  localparam int AW    = 2 * FP_WIDTH;
  localparam int CW    = $clog2(FP_WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(FP_WIDTH - 1);

  localparam logic [AW-1:0] MAX_POS =
    AW'({1'b0, {(FP_WIDTH-1){1'b1}}});
  localparam logic [AW-1:0] NEG_LIM =
    AW'({1'b1, {(FP_WIDTH-1){1'b0}}});

`ifdef FP_MUL_ROUND_EN
  localparam logic [AW-1:0] RND = AW'(1) << (FBITS - 1);
`else
  localparam logic [AW-1:0] RND = '0;
`endif

  localparam logic [FP_WIDTH-1:0] SAT_POS =
    {1'b0, {(FP_WIDTH-1){1'b1}}};
  localparam logic [FP_WIDTH-1:0] SAT_NEG =
    {1'b1, {(FP_WIDTH-1){1'b0}}};

  logic [1:0]          state;
  logic [CW-1:0]       cnt;
  logic [AW-1:0]       acc;
  logic [AW-1:0]       ma;
  logic [FP_WIDTH-1:0] mb;
  logic                sign;

  logic [FP_WIDTH-1:0] a_mag;
  logic [FP_WIDTH-1:0] b_mag;
  logic [AW-1:0]       acc_r;
  logic [AW-1:0]       mag;
  logic [FP_WIDTH-1:0] mag_w;
  logic [FP_WIDTH-1:0] res;
  logic                pos_ovf;
  logic                neg_ovf;

  // Most-negative input maps to 2^(W-1) as an unsigned magnitude.
  assign a_mag = a[FP_WIDTH-1] ? (~a + 1'b1) : a;
  assign b_mag = b[FP_WIDTH-1] ? (~b + 1'b1) : b;

  assign acc_r   = acc + RND;
  assign mag     = acc_r >> FBITS;
  assign mag_w   = mag[FP_WIDTH-1:0];
  assign res     = sign ? (~mag_w + 1'b1) : mag_w;
  assign pos_ovf = !sign && (mag > MAX_POS);
  assign neg_ovf = sign && (mag > NEG_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      acc   <= '0;
      ma    <= '0;
      mb    <= '0;
      sign  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      valid <= 1'b0;
      ovf   <= 1'b0;
      val   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            ma    <= AW'(a_mag);
            mb    <= b_mag;
            sign  <= a[FP_WIDTH-1] ^ b[FP_WIDTH-1];
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          if (mb[0]) acc <= acc + ma;
          ma  <= ma << 1;
          mb  <= mb >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= S_FIN;
        end
        S_FIN: begin
          if (pos_ovf) begin
            val   <= SAT_POS;
            ovf   <= 1'b1;
            valid <= 1'b0;
          end else if (neg_ovf) begin
            val   <= SAT_NEG;
            ovf   <= 1'b1;
            valid <= 1'b0;
          end else begin
            val   <= res;
            ovf   <= 1'b0;
            valid <= 1'b1;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Scoreboard bench for fp_mul_seq: latency, sign, saturation,
// rounding edges, back-to-back, ignored start and mid-op reset.
module tb_fp_mul_seq;

  localparam int W  = 25;
  localparam int FB = 21;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, valid, ovf;
  logic [W-1:0] val;

  int checks = 0;
  int errors = 0;

  logic [W+1:0] sb_q[$];
  logic [W-1:0] last_val;
  logic         last_valid, last_ovf;

  fp_mul_seq #(.FP_WIDTH(W), .FP_INT(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b),
    .busy(busy), .done(done),
    .valid(valid), .ovf(ovf), .val(val)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W+1:0] model(
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    longint sx, sy, p, m;
    logic neg;
    logic [W-1:0] v;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p = sx * sy;
    neg = (p < 0);
    m = neg ? -p : p;
`ifdef FP_MUL_ROUND_EN
    m = m + (longint'(1) << (FB - 1));
`endif
    m = m >> FB;
    if (!neg && m > ((longint'(1) << (W-1)) - 1))
      return {25'h0FFFFFF, 1'b0, 1'b1};
    if (neg && m > (longint'(1) << (W-1)))
      return {25'h1000000, 1'b0, 1'b1};
    v = neg ? W'(-m) : W'(m);
    return {v, 1'b1, 1'b0};
  endfunction

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    a = x;
    b = y;
    start = 1'b1;
    sb_q.push_back(model(x, y));
  endtask

  // Waits for done; inject>0 drives a stray start with other operands
  // in that cycle of the operation.
  task automatic wait_done(input string name, input int inject);
    int lat;
    bit busy_bad;
    logic [W+1:0] e;
    lat = 0;
    busy_bad = 0;
    do begin
      tick();
      lat++;
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      if (lat == inject) start = 1'b1;
      if (!done && busy !== 1'b1) busy_bad = 1;
    end while (done !== 1'b1 && lat < 80);
    start = 1'b0;
    checks++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL %s latency got %0d want %0d", name, lat, LAT);
    end
    checks++;
    if (busy_bad) begin
      errors++;
      $display("FAIL %s busy dropped got 0 want 1", name);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy at done got %b want 0", name, busy);
    end
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty got done want none", name);
    end else begin
      e = sb_q.pop_front();
      checks++;
      if ({val, valid, ovf} !== e) begin
        errors++;
        $display("FAIL %s result got %h/%b/%b want %h/%b/%b",
          name, val, valid, ovf, e[W+1:2], e[1], e[0]);
      end
    end
    last_val = val;
    last_valid = valid;
    last_ovf = ovf;
  endtask

  task automatic expect_val(input string name, input logic [W-1:0] v,
                            input logic vl, input logic ov);
    checks++;
    if ({last_val, last_valid, last_ovf} !== {v, vl, ov}) begin
      errors++;
      $display("FAIL %s got %h/%b/%b want %h/%b/%b",
        name, last_val, last_valid, last_ovf, v, vl, ov);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, valid, ovf, val} !== '0) begin
      errors++;
      $display("FAIL reset got %b%b%b%b %h want 0000 0",
        busy, done, valid, ovf, val);
    end
  endtask

  task automatic test_basic();
    issue(25'h0300000, 25'h0400000);
    wait_done("pos_1p5x2", 0);
    expect_val("pos_1p5x2_const", 25'h0600000, 1'b1, 1'b0);
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse got %b want 0", done);
    end
  endtask

  task automatic test_back_to_back();
    issue(25'h1D00000, 25'h0400000);
    wait_done("neg_1p5x2", 0);
    expect_val("neg_1p5x2_const", 25'h1A00000, 1'b1, 1'b0);
    issue(25'h0000000, 25'h0000000);
    wait_done("b2b_zero", 0);
    expect_val("b2b_zero_const", 25'h0000000, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    issue(25'h0800000, 25'h0800000);
    wait_done("ovf_pos", 0);
    expect_val("ovf_pos_const", 25'h0FFFFFF, 1'b0, 1'b1);
    issue(25'h1800000, 25'h0800000);
    wait_done("ovf_neg", 0);
    expect_val("ovf_neg_const", 25'h1000000, 1'b0, 1'b1);
    issue(25'h1000000, 25'h0200000);
    wait_done("neg_boundary", 0);
    expect_val("neg_boundary_const", 25'h1000000, 1'b1, 1'b0);
    issue(25'h1000000, 25'h1000000);
    wait_done("minxmin", 0);
  endtask

  task automatic test_rounding();
    issue(25'h0000001, 25'h0100000);
    wait_done("rnd_pos", 0);
`ifdef FP_MUL_ROUND_EN
    expect_val("rnd_pos_const", 25'h0000001, 1'b1, 1'b0);
`else
    expect_val("rnd_pos_const", 25'h0000000, 1'b1, 1'b0);
`endif
    issue(25'h1FFFFFF, 25'h0100000);
    wait_done("rnd_neg", 0);
`ifdef FP_MUL_ROUND_EN
    expect_val("rnd_neg_const", 25'h1FFFFFF, 1'b1, 1'b0);
`else
    expect_val("rnd_neg_const", 25'h0000000, 1'b1, 1'b0);
`endif
  endtask

  task automatic test_ignore_start();
    issue(25'h0500000, 25'h1C00000);
    wait_done("ignore_start", 6);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL ignore_start queue got %0d want 0", sb_q.size());
    end
    repeat (LAT + 3) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL ignore_start extra got done=%b busy=%b want 0 0",
          done, busy);
      end
    end
  endtask

  task automatic test_mid_reset();
    bit seen;
    issue(25'h0300000, 25'h0300000);
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(sb_q.pop_back());
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset busy got %b want 0", busy);
    end
    seen = 0;
    repeat (LAT + 5) begin
      tick();
      if (done === 1'b1) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL mid_reset stray done got 1 want 0");
    end
    issue(25'h0300000, 25'h0300000);
    wait_done("after_reset", 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      issue(W'($urandom), W'($urandom_range(0, 25'h0FFFFF)));
      wait_done("random", 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_rounding();
    test_ignore_start();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
